// File: rtl/mult_arb_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
//   N_DEF / NREQ_DEF : default operand width and requester count
//   calc_idw()       : requester-ID width, max(1, clog2(nreq))
//   mult_rsp_t       : packed {product, id} record at the default widths
package mult_arb_pkg;

    localparam int unsigned N_DEF    = 16;
    localparam int unsigned NREQ_DEF = 4;

    function automatic int unsigned calc_idw(input int unsigned nreq);
        int unsigned w;
        w = 1;
        for (int unsigned i = 1; i < 31; i++) begin
            if ((32'd1 << i) < nreq) w = i + 1;
        end
        return w;
    endfunction

    localparam int unsigned IDW_DEF = calc_idw(NREQ_DEF);

    typedef struct packed {
        logic [2*N_DEF-1:0] p;
        logic [IDW_DEF-1:0] id;
    } mult_rsp_t;

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
//   req   : request vector, one bit per requester
//   ptr   : index where the search starts; wraps NREQ-1 -> 0
//   grant : first requesting index found from ptr
//   any   : at least one request bit is set (grant is 0 otherwise)
module rr_pick
    import mult_arb_pkg::*;
#(
    parameter int unsigned NREQ = NREQ_DEF,
    parameter int unsigned IDW  = calc_idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [IDW-1:0]  grant,
    output logic            any
);

    always_comb begin
        logic [31:0]    idx_w;
        logic [IDW-1:0] idx;
        grant = '0;
        any   = 1'b0;
        idx_w = '0;
        idx   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx_w = (32'(ptr) + i) % NREQ;
            idx   = idx_w[IDW-1:0];
            if (!any && req[idx]) begin
                any   = 1'b1;
                grant = idx;
            end
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter and two-stage sequencer sharing one external
// combinational signed NxN multiplier among NREQ requesters.
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/ready    : per-requester handshake (ready is one-hot or zero)
//   req_a, req_x       : flattened operands, requester k at [k*N +: N]
//   mul_a, mul_x       : registered operands to the external multiplier
//   mul_p              : 2N-bit signed product returned by the multiplier
//   rsp_valid/ready    : response handshake
//   rsp_p, rsp_id      : product and originating requester index
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int unsigned N    = N_DEF,
    parameter  int unsigned NREQ = NREQ_DEF,
    localparam int unsigned IDW  = calc_idw(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_x,
    output logic [N-1:0]      mul_a,
    output logic [N-1:0]      mul_x,
    input  logic [2*N-1:0]    mul_p,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [2*N-1:0]    rsp_p,
    output logic [IDW-1:0]    rsp_id
);

    typedef struct packed {
        logic [2*N-1:0] p;
        logic [IDW-1:0] id;
    } rsp_rec_t;

    // OP stage
    logic           op_v;
    logic [N-1:0]   op_a;
    logic [N-1:0]   op_x;
    logic [IDW-1:0] op_id;

    // RSP stage
    logic     rsp_v;
    rsp_rec_t rsp_q;

    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] grant;
    logic           any;
    logic           rsp_adv;
    logic           op_acc;
    logic           accept;
    logic [N-1:0]   sel_a;
    logic [N-1:0]   sel_x;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant),
        .any   (any)
    );

    // The OP stage may take a new pair whenever its contents can move on,
    // so a full pipe still accepts one per cycle while rsp_ready is high.
    assign rsp_adv = !rsp_v || rsp_ready;
    assign op_acc  = !op_v || rsp_adv;
    assign accept  = any && op_acc;

    assign ptr_next = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        req_ready = '0;
        if (any) req_ready[grant] = op_acc;
    end

    always_comb begin
        sel_a = '0;
        sel_x = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (grant == IDW'(k)) begin
                sel_a = req_a[k*N +: N];
                sel_x = req_x[k*N +: N];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_v  <= 1'b0;
            op_a  <= '0;
            op_x  <= '0;
            op_id <= '0;
            ptr   <= '0;
            rsp_v <= 1'b0;
            rsp_q <= '0;
        end else begin
            if (accept) begin
                op_v  <= 1'b1;
                op_a  <= sel_a;
                op_x  <= sel_x;
                op_id <= grant;
                ptr   <= ptr_next;
            end else if (op_acc) begin
                op_v  <= 1'b0;
            end
            if (rsp_adv) begin
                rsp_v   <= op_v;
                rsp_q.p  <= mul_p;
                rsp_q.id <= op_id;
            end
        end
    end

    assign mul_a     = op_a;
    assign mul_x     = op_x;
    assign rsp_valid = rsp_v;
    assign rsp_p     = rsp_q.p;
    assign rsp_id    = rsp_q.id;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter at N=8, NREQ=4.
// A queue-based model predicts ready, response timing and contents every
// cycle; table vectors and short sequences add explicit constant checks.
module tb_mult_share_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_a;
    logic [31:0] req_x;
    logic [7:0]  mul_a;
    logic [7:0]  mul_x;
    logic [15:0] mul_p;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_p;
    logic [1:0]  rsp_id;

    always #5 clk = ~clk;

    // external shared multiplier
    assign mul_p = $signed({{8{mul_a[7]}}, mul_a}) * $signed({{8{mul_x[7]}}, mul_x});

    mult_share_arbiter #(
        .N    (8),
        .NREQ (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_x     (req_x),
        .mul_a     (mul_a),
        .mul_x     (mul_x),
        .mul_p     (mul_p),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_p     (rsp_p),
        .rsp_id    (rsp_id)
    );

    int passed = 0;
    int total  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // Items in flight, oldest first, stamped with the cycle of acceptance.
    // At most two may be in flight; the oldest is presented from one edge
    // after it was accepted.
    typedef struct {
        logic [15:0] p;
        int          id;
        int          stamp;
    } item_t;

    item_t q[$];
    int    mptr      = 0;
    int    cyc       = 0;
    bit    auto_drop = 1'b1;

    // observations from the latest tick
    int          last_dut_g;
    bit          last_rsp_fire;
    logic [15:0] last_rsp_p;
    int          last_rsp_id;

    task automatic tick();
        int          g;
        bit          any, acc_ok, pres;
        logic [3:0]  exp_ready;
        logic signed [7:0] sa, sx;
        int          prod;
        item_t       it;
        int          drop_g;
        #1;
        pres   = (q.size() > 0) && ((cyc - q[0].stamp) >= 1);
        acc_ok = (q.size() < 2) || (pres && rsp_ready);
        any = 1'b0;
        g   = 0;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = (mptr + k) % 4;
            if (!any && req_valid[i]) begin
                any = 1'b1;
                g   = i;
            end
        end
        exp_ready = (any && acc_ok) ? (4'b0001 << g) : 4'b0000;
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(pres));
        if (pres) begin
            chk("rsp_p", 32'(rsp_p), 32'(q[0].p));
            chk("rsp_id", 32'(rsp_id), q[0].id);
        end
        last_dut_g = -1;
        for (int k = 0; k < 4; k++) if (req_ready[k]) last_dut_g = k;
        last_rsp_fire = rsp_valid && rsp_ready;
        last_rsp_p    = rsp_p;
        last_rsp_id   = 32'(rsp_id);
        drop_g = -1;
        @(posedge clk);
        if (pres && rsp_ready) void'(q.pop_front());
        if (any && acc_ok) begin
            sa   = req_a[g*8 +: 8];
            sx   = req_x[g*8 +: 8];
            prod = int'(sa) * int'(sx);
            it.p     = prod[15:0];
            it.id    = g;
            it.stamp = cyc + 1;
            q.push_back(it);
            mptr = (g + 1) % 4;
            if (auto_drop) drop_g = g;
        end
        cyc++;
        @(negedge clk);
        if (drop_g >= 0) req_valid[drop_g] = 1'b0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        @(posedge clk);
        q.delete();
        mptr = 0;
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_mul_a", 32'(mul_a), 32'd0);
        chk("rst_mul_x", 32'(mul_x), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
    endtask

    task automatic flush();
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (4) tick();
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic [7:0]  a;
        logic [7:0]  x;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int acc_at;
        bit got;
        int n_acc;
        int ids[$];
        int exp_g[6];
        int exp_s[4];

        rst = 1'b1; req_valid = '0; rsp_ready = 1'b1; req_a = '0; req_x = '0;
        vecs[0] = '{8'hFD, 8'h05, 16'hFFF1};  // -3 * 5
        vecs[1] = '{8'h80, 8'h80, 16'h4000};  // -128 * -128
        vecs[2] = '{8'h80, 8'h7F, 16'hC080};  // -128 * 127
        vecs[3] = '{8'h00, 8'hFF, 16'h0000};  // 0 * -1
        vecs[4] = '{8'h7F, 8'h7F, 16'h3F01};  // 127 * 127
        vecs[5] = '{8'hFF, 8'hFF, 16'h0001};  // -1 * -1
        vecs[6] = '{8'h01, 8'h80, 16'hFF80};  // 1 * -128

        @(negedge clk);
        do_reset();

        // single requests on req0, latency and value per table row
        auto_drop = 1'b1;
        for (int v = 0; v < 7; v++) begin
            req_a[7:0] = vecs[v].a;
            req_x[7:0] = vecs[v].x;
            req_valid  = 4'b0001;
            rsp_ready  = 1'b1;
            acc_at = -1;
            got    = 1'b0;
            for (int t = 0; t < 10 && !got; t++) begin
                tick();
                if (last_dut_g == 0 && acc_at < 0) acc_at = t;
                if (last_rsp_fire) begin
                    got = 1'b1;
                    chk("vec_p", 32'(last_rsp_p), 32'(vecs[v].p));
                    chk("vec_id", last_rsp_id, 0);
                    chk("vec_latency", t - acc_at, 2);
                end
            end
            chk("vec_timeout", 32'(got), 32'd1);
        end
        flush();

        // all four continuously valid
        do_reset();
        auto_drop = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_a[k*8 +: 8] = 8'(k + 2);
            req_x[k*8 +: 8] = 8'(-(k + 1));
        end
        exp_g = '{0, 1, 2, 3, 0, 1};
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        ids.delete();
        for (int t = 0; t < 8; t++) begin
            tick();
            if (t < 6) chk("rr_grant", last_dut_g, exp_g[t]);
            if (last_rsp_fire) ids.push_back(last_rsp_id);
        end
        chk("rr_rsp_count", ids.size(), 6);
        for (int i = 0; i < 6 && i < ids.size(); i++) chk("rr_rsp_id", ids[i], exp_g[i]);
        flush();

        // sparse requesters 1 and 3
        do_reset();
        exp_s = '{1, 3, 1, 3};
        req_valid = 4'b1010;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("sparse_grant", last_dut_g, exp_s[t]);
        end
        flush();

        // backpressure: only two taken while rsp_ready is low
        do_reset();
        auto_drop = 1'b1;
        req_valid = 4'b0111;
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int t = 0; t < 5; t++) begin
            tick();
            if (last_dut_g >= 0) n_acc++;
        end
        chk("bp_accepts", n_acc, 2);
        rsp_ready = 1'b1;
        ids.delete();
        for (int t = 0; t < 10 && ids.size() < 3; t++) begin
            tick();
            if (last_rsp_fire) ids.push_back(last_rsp_id);
        end
        chk("bp_rsp_count", ids.size(), 3);
        for (int i = 0; i < 3 && i < ids.size(); i++) chk("bp_rsp_id", ids[i], i);
        flush();

        // reset with two in flight
        do_reset();
        req_valid = 4'b0011;
        rsp_ready = 1'b0;
        repeat (3) tick();
        do_reset();
        req_valid = 4'hF;
        rsp_ready = 1'b1;
        tick();
        chk("post_rst_grant", last_dut_g, 0);
        flush();

        // randomized traffic against the model
        for (int t = 0; t < 400; t++) begin
            for (int k = 0; k < 4; k++) begin
                if (!req_valid[k] && ($urandom % 2 == 0)) begin
                    req_a[k*8 +: 8] = 8'($urandom);
                    req_x[k*8 +: 8] = 8'($urandom);
                    req_valid[k]    = 1'b1;
                end
            end
            rsp_ready = ($urandom % 10) < 7;
            if ($urandom % 64 == 0) do_reset();
            else tick();
        end
        flush();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter and two-stage sequencer that shares one combinational signed N×N array multiplier among NREQ requesters. Each requester offers an operand pair over a valid/ready handshake. The block registers the winning pair onto the multiplier inputs, captures the 2N-bit product, and returns it tagged with the requester ID over a valid/ready response port. It sits between client datapaths and the multiplier instance in the parent, sustaining one product per cycle under full load.

## Interface
- N, 16: operand width; two's-complement signed
- NREQ, 4: number of requesters, 2..16
- IDW, max(1, clog2(NREQ)): ID width (localparam)

- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NREQ  per-requester operand valid
- req_ready  out  NREQ  per-requester accept; at most one bit high
- req_a  in  NREQ*N  flattened multiplicands; requester k at [k*N +: N]
- req_x  in  NREQ*N  flattened multipliers, same packing
- mul_a  out  N  registered multiplicand to multiplier
- mul_x  out  N  registered multiplier to multiplier
- mul_p  in  2N  combinational signed product of mul_a*mul_x
- rsp_valid  out  1  result valid
- rsp_ready  in  1  downstream accept
- rsp_p  out  2N  signed product
- rsp_id  out  IDW  index of originating requester

## Operation
- Pipeline stages:
  - OP stage: op_v, op_a, op_x, op_id. mul_a = op_a, mul_x = op_x.
  - RSP stage: rsp_valid, rsp_p, rsp_id.
- Advance rules:
  - rsp_adv = !rsp_valid || rsp_ready
  - op_acc = !op_v || rsp_adv
- Arbitration:
  - Combinational round-robin search over req_valid, starting at pointer ptr and wrapping NREQ-1 → 0.
  - The first valid index found is the winner g.
  - req_ready[g] = op_acc; all other bits are 0. If no req_valid bit is set, req_ready = 0.
  - req_ready does not depend on rsp_ready except through op_acc.
- On accept (req_valid[g] && req_ready[g]):
  - op_a, op_x, op_id ← req_a[g], req_x[g], g; op_v ← 1.
  - ptr ← (g+1) mod NREQ.
  - If there is no accept, ptr holds. Fairness guarantee: a continuously valid requester waits at most NREQ-1 grants.
- OP stage without accept: if op_acc && no accept, op_v ← 0. Otherwise op_v, op_a, op_x, op_id hold.
- RSP stage on rsp_adv:
  - rsp_valid ← op_v; rsp_p ← mul_p; rsp_id ← op_id.
  - When !rsp_adv, rsp_p and rsp_id are held bit-stable.
- Arithmetic: full-precision signed product with no truncation. Corner case: (−2^(N−1))² = 2^(2N−2) is representable.
- Ordering: responses leave in acceptance order; nothing is dropped or duplicated.

## Timing
- Reset values: op_v=0, rsp_valid=0, ptr=0, op_a=op_x=0, op_id=0, rsp_p=0, rsp_id=0.
  - Consequently mul_a = mul_x = 0 and req_ready is valid in the first cycle after reset.
- Latency: accept at edge t → mul_a/mul_x driven during cycle t+1 → rsp_valid high during cycle t+2.
  - The mul_p path is one full cycle, OP register to RSP register.
- Throughput: 1 accept/cycle while rsp_ready=1.
- Backpressure: at most 2 operations in flight.
  - With rsp_valid=1 and rsp_ready=0, op_acc=0 if op_v=1, so all req_ready are 0.
  - With rsp_valid=1, rsp_ready=0 and op_v=0, one more accept is allowed.
- Simultaneous events in one cycle are legal: rsp handoff, OP→RSP move, and a new accept.
- Reset mid-operation: all in-flight operations are discarded. No response is emitted after rst; ptr returns to 0.
- Requester protocol: req_a, req_x held stable while req_valid=1 and not accepted. The block does not check this.

## Structure
- Shared package mult_arb_pkg holds:
  - IDW computation function
  - default N/NREQ constants
  - packed response record: p, id
- One sub-module is natural: rr_pick (NREQ-wide combinational round-robin priority picker).
  - Inputs: req vector, ptr.
  - Outputs: grant index, any.
- The multiplier is instantiated in the parent, not here.

## Test plan
Configuration for all tests: N=8, NREQ=4.
- Single request: req0 only, a=−3, x=5, rsp_ready=1 → rsp_valid two cycles after accept, rsp_p=16'hFFF1 (−15), rsp_id=0.
- All four valid continuously, rsp_ready=1 → accepts in order 0,1,2,3,0,1; one per cycle; rsp_id follows the same sequence.
- Corners: a=x=−128 → rsp_p=16'h4000. a=−128, x=127 → 16'hC080 (−16256). a=0, x=−1 → 0.
- Sparse requesters: only req1 and req3 valid, ptr=0 → grants alternate 1,3,1,3; req0 and req2 never see ready.
- Backpressure: three requests, rsp_ready=0 for 5 cycles → exactly 2 accepted, then all req_ready=0; rsp_p/rsp_id stable. Release → third accepted; all three delivered in order.
- Reset mid-operation: rst for one cycle with 2 in flight → rsp_valid=0 next cycle, no stale response, next grant starts search from req0.
